// File: rtl/wb_arb2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter and its watchdog.
package wb_arb2_pkg;

  // One-hot state encoding doubles as the grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_e;

  localparam int WB_ARB_WD_W = 8;
  localparam int NUM_MASTERS = 2;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  function automatic arb_state_e gnt_state(input logic idx);
    return idx ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Bus watchdog: counts consecutive unterminated strobe cycles and flags a timeout.
module wb_arb_wdog
  import wb_arb2_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active_i,
  input  logic clear_i,
  output logic fire_o
);

  localparam logic [WB_ARB_WD_W-1:0] LIMIT = WB_ARB_WD_W'(timeout_cycles);

  logic [WB_ARB_WD_W-1:0] count_q;
  logic [WB_ARB_WD_W-1:0] count_d;

  assign fire_o = (count_q == LIMIT);

  // A firing count restarts so a held strobe sees err periodically.
  always_comb begin
    count_d = count_q + 1'b1;
    if (!active_i || clear_i || fire_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Round-robin two-master Wishbone arbiter; grant held for a whole cyc burst, watchdog-terminated.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  arb_state_e state_q;
  logic       last_q;

  wb_req_t    req [NUM_MASTERS];
  wb_req_t    gnt_req;
  logic       owned;
  logic       gnt_active;
  logic       wd_fire;
  logic       stb_kill;
  logic [NUM_MASTERS-1:0] ack_vec;
  logic [NUM_MASTERS-1:0] err_vec;

  assign req[0] = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i};
  assign req[1] = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i};

  // Arbitration FSM; the grant is never preempted while the owner holds cyc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_q <= gnt_state(~last_q);
            last_q  <= ~last_q;
          end else if (m0_cyc_i) begin
            state_q <= ST_GNT0;
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= ST_GNT1;
            last_q  <= 1'b1;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state_q <= ST_GNT1;
              last_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state_q <= ST_GNT0;
              last_q  <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o = state_q;
  assign owned   = (state_q != ST_IDLE);
  assign gnt_req = (state_q == ST_GNT1) ? req[1] : req[0];

  assign gnt_active = owned & gnt_req.cyc & gnt_req.stb;

  // Every grant change passes through a cycle where the owner's cyc is low,
  // so dropping active_i also covers clearing on handover and aborted cycles.
  wb_arb_wdog #(
    .timeout_cycles(timeout_cycles)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .active_i(gnt_active),
    .clear_i (s_ack_i | s_err_i),
    .fire_o  (wd_fire)
  );

  // A real ack in the same cycle beats the timeout.
  assign stb_kill = wd_fire & ~s_ack_i;

  assign s_cyc_o = owned & gnt_req.cyc;
  assign s_stb_o = gnt_active & ~stb_kill;
  assign s_we_o  = gnt_req.we;
  assign s_adr_o = gnt_req.adr;
  assign s_sel_o = gnt_req.sel;
  assign s_dat_o = gnt_req.dat;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_term
    assign ack_vec[gi] = s_ack_i & state_q[gi];
    assign err_vec[gi] = (s_err_i | stb_kill) & state_q[gi];
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];
  assign m0_err_o = err_vec[0];
  assign m1_err_o = err_vec[1];

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed scenarios plus randomized traffic against a model.
module tb_wb_arb2;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i;
  logic [1:0]  grant_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: owner 0 = none, 1 = master 0, 2 = master 1; last = index of last winner.
  int mdl_owner;
  int mdl_last;
  int mdl_stall;

  always #5 clk = ~clk;

  wb_arb2 #(.timeout_cycles(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    next_cycle();
    next_cycle();
    reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    logic [107:0] obs;
    idle_inputs();
    reset_n = 0;
    next_cycle();
    obs = {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
           s_we_o, s_adr_o, s_sel_o, s_dat_o};
    chk_cnt++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h exp 0", obs);
    else pass_cnt++;
    m0_cyc_i = 1; m0_stb_i = 1;
    next_cycle();
    chk_cnt++;
    if ({grant_o, s_cyc_o} !== 3'b000) $display("FAIL reset_hold: got %b exp 000", {grant_o, s_cyc_o});
    else pass_cnt++;
    idle_inputs();
    next_cycle();
    reset_n = 1;
    next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
    #1;
    chk_cnt++;
    if ({grant_o, s_cyc_o} !== 3'b000) $display("FAIL sr_latency: got %b exp 000", {grant_o, s_cyc_o});
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if ({grant_o, s_cyc_o, s_stb_o, m0_ack_o, s_adr_o} !== {2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_0100})
      $display("FAIL sr_grant: got %h exp %h", {grant_o, s_cyc_o, s_stb_o, m0_ack_o, s_adr_o},
               {2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_0100});
    else pass_cnt++;
    next_cycle();
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
    #1;
    chk_cnt++;
    if (m0_ack_o !== 1'b1) $display("FAIL sr_ack: got %b exp 1", m0_ack_o);
    else pass_cnt++;
    chk_cnt++;
    if (m0_dat_o !== 32'hDEADBEEF) $display("FAIL sr_data: got %h exp deadbeef", m0_dat_o);
    else pass_cnt++;
    chk_cnt++;
    if (m1_ack_o !== 1'b0) $display("FAIL sr_m1_ack: got %b exp 0", m1_ack_o);
    else pass_cnt++;
    next_cycle();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    #1;
    chk_cnt++;
    if ({m0_ack_o, s_cyc_o} !== 2'b00) $display("FAIL sr_release: got %b exp 00", {m0_ack_o, s_cyc_o});
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (grant_o !== 2'b00) $display("FAIL sr_idle: got %b exp 00", grant_o);
    else pass_cnt++;
    $display("test_single_read done");
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_adr;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      exp_g = (r == 1) ? 2'b10 : 2'b01;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000 + 32'(r * 16);
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h2000 + 32'(r * 16);
      exp_adr = (r == 1) ? m1_adr_i : m0_adr_i;
      next_cycle();
      for (int b = 0; b < 4; b++) begin
        s_ack_i = 1;
        #1;
        chk_cnt++;
        if ({grant_o, s_adr_o, m0_ack_o, m1_ack_o} !== {exp_g, exp_adr, exp_g[0], exp_g[1]})
          $display("FAIL cont_r%0d_b%0d: got %h exp %h", r, b,
                   {grant_o, s_adr_o, m0_ack_o, m1_ack_o}, {exp_g, exp_adr, exp_g[0], exp_g[1]});
        else pass_cnt++;
        next_cycle();
      end
      idle_inputs();
      #1;
      chk_cnt++;
      if (s_cyc_o !== 1'b0) $display("FAIL cont_drop_r%0d: got %b exp 0", r, s_cyc_o);
      else pass_cnt++;
      next_cycle();
      $display("contention burst %0d grant %b", r, exp_g);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h3000;
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h4000;
    for (int b = 0; b < 8; b++) begin
      s_ack_i = 1; m1_adr_i = 32'h3000 + 32'(b * 4);
      #1;
      chk_cnt++;
      if ({grant_o, s_adr_o, m0_ack_o, m1_ack_o} !== {2'b10, m1_adr_i, 1'b0, 1'b1})
        $display("FAIL b2b_beat%0d: got %h exp %h", b, {grant_o, s_adr_o, m0_ack_o, m1_ack_o},
                 {2'b10, m1_adr_i, 1'b0, 1'b1});
      else pass_cnt++;
      next_cycle();
    end
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    #1;
    chk_cnt++;
    if (grant_o !== 2'b10) $display("FAIL b2b_hold: got %b exp 10", grant_o);
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if ({grant_o, s_cyc_o, s_adr_o} !== {2'b01, 1'b1, 32'h4000})
      $display("FAIL b2b_handover: got %h exp %h", {grant_o, s_cyc_o, s_adr_o}, {2'b01, 1'b1, 32'h4000});
    else pass_cnt++;
    idle_inputs();
    next_cycle();
    next_cycle();
    $display("test_back_to_back done");
  endtask

  task automatic test_watchdog();
    logic e;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h5000;
    next_cycle();
    for (int k = 1; k <= 15; k++) begin
      e = (k % 5 == 0);
      #1;
      chk_cnt++;
      if ({m0_err_o, m1_err_o, s_stb_o} !== {e, 1'b0, ~e})
        $display("FAIL wd_cycle%0d: got %b exp %b", k, {m0_err_o, m1_err_o, s_stb_o}, {e, 1'b0, ~e});
      else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    $display("test_watchdog done");
  endtask

  task automatic test_ack_vs_fire();
    logic ea, ee;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h6000;
    next_cycle();
    for (int k = 1; k <= 10; k++) begin
      s_ack_i = (k == 5);
      ea = (k == 5);
      ee = (k == 10);
      #1;
      chk_cnt++;
      if ({m0_ack_o, m0_err_o, s_stb_o} !== {ea, ee, ~ee})
        $display("FAIL avf_cycle%0d: got %b exp %b", k, {m0_ack_o, m0_err_o, s_stb_o}, {ea, ee, ~ee});
      else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    $display("test_ack_vs_fire done");
  endtask

  task automatic test_async_reset();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h7000;
    next_cycle();
    s_ack_i = 1;
    #2;
    reset_n = 0;
    #1;
    chk_cnt++;
    if ({s_cyc_o, s_stb_o, grant_o} !== 4'b0000)
      $display("FAIL async_reset: got %b exp 0000", {s_cyc_o, s_stb_o, grant_o});
    else pass_cnt++;
    idle_inputs();
    next_cycle();
    reset_n = 1;
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    next_cycle();
    chk_cnt++;
    if (grant_o !== 2'b01) $display("FAIL async_first_win: got %b exp 01", grant_o);
    else pass_cnt++;
    idle_inputs();
    next_cycle();
    next_cycle();
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int          b0, b1, ack_pct, max_len;
    logic        gcyc, gstb, fire, kill, own0, own1, go0, go1;
    logic [31:0] gadr;
    logic [103:0] obs, exp_v;
    int          new_owner;
    int          errs_seen;
    do_reset();
    mdl_owner = 0; mdl_last = 1; mdl_stall = 0;
    b0 = 0; b1 = 0; errs_seen = 0;
    for (int c = 0; c < 600; c++) begin
      ack_pct = (c < 300) ? 60 : 8;
      max_len = (c < 300) ? 8 : 20;
      if (b0 == 0 && $urandom_range(0, 3) == 0) b0 = $urandom_range(1, max_len);
      if (b1 == 0 && $urandom_range(0, 3) == 0) b1 = $urandom_range(1, max_len);
      m0_cyc_i = (b0 != 0);
      m1_cyc_i = (b1 != 0);
      if (b0 != 0) b0--;
      if (b1 != 0) b1--;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 15) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 15) != 0);
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_adr_i = $urandom; m1_adr_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      m0_dat_i = $urandom; m1_dat_i = $urandom;
      s_dat_i = $urandom;
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      s_err_i = ($urandom_range(0, 99) < 3);
      #1;
      own0 = (mdl_owner == 1);
      own1 = (mdl_owner == 2);
      gcyc = own0 ? m0_cyc_i : (own1 ? m1_cyc_i : 1'b0);
      gstb = gcyc & (own0 ? m0_stb_i : m1_stb_i);
      gadr = own1 ? m1_adr_i : m0_adr_i;
      fire = (mdl_stall == TO);
      kill = fire & ~s_ack_i;
      if (kill) errs_seen++;
      exp_v = {own1, own0, gcyc, gstb & ~kill,
               s_ack_i & own0, (s_err_i | kill) & own0,
               s_ack_i & own1, (s_err_i | kill) & own1,
               gadr, s_dat_i, s_dat_i};
      obs = {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
             s_adr_o, m0_dat_o, m1_dat_o};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL rand_cycle%0d: got %h exp %h", c, obs, exp_v);
      else pass_cnt++;
      // Advance the model with this cycle's inputs.
      if (!gstb || s_ack_i || s_err_i || fire) mdl_stall = 0;
      else mdl_stall++;
      go0 = m0_cyc_i; go1 = m1_cyc_i;
      new_owner = mdl_owner;
      if (mdl_owner == 0) begin
        if (go0 && go1) new_owner = (mdl_last == 1) ? 1 : 2;
        else if (go0) new_owner = 1;
        else if (go1) new_owner = 2;
      end else if (!gcyc) begin
        if (own0 && go1) new_owner = 2;
        else if (own1 && go0) new_owner = 1;
        else new_owner = 0;
      end
      if (new_owner != mdl_owner && new_owner != 0) mdl_last = new_owner - 1;
      mdl_owner = new_owner;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    $display("test_random done, %0d watchdog terminations modelled", errs_seen);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_watchdog();
    test_ack_vs_fire();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
